// File: rtl/jtpopeye_sync.sv
// Sync conditioner for jtpopeye_game: registered RGB/blanking, HS/VS, line lock.
// Define JTPOPEYE_SYNC_BLANK_EN to force colour to black during blanking.
module jtpopeye_sync #(
  parameter int HS_START = 16,
  parameter int HS_WIDTH = 48,
  parameter int VS_START = 4,
  parameter int VS_WIDTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl2_cen,
  input  logic [2:0] red_i,
  input  logic [2:0] green_i,
  input  logic [2:0] blue_i,
  input  logic       HB_i,
  input  logic       VB_i,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [2:0] blue,
  output logic       HB,
  output logic       VB,
  output logic       HS,
  output logic       VS,
  output logic [9:0] line_len,
  output logic       locked
);

  localparam logic [10:0] HS_LO = 11'(HS_START);
  localparam logic [10:0] HS_HI = 11'(HS_START + HS_WIDTH);
  localparam logic [6:0]  VS_LO = 7'(VS_START);
  localparam logic [6:0]  VS_HI = 7'(VS_START + VS_WIDTH);

  logic       hb_l;
  logic       vb_l;
  logic [9:0] hcnt;
  logic [5:0] vcnt;
  logic       hvalid;
  logic       vvalid;
  logic [1:0] match_cnt;

  logic       hb_rise;
  logic       vb_rise;
  logic [9:0] hcnt_n;
  logic [5:0] vcnt_n;
  logic       hvalid_n;
  logic       vvalid_n;
  logic       hs_n;
  logic       vs_n;
  logic [9:0] meas;
  logic       meas_en;
  logic [9:0] line_len_n;
  logic [1:0] match_cnt_n;
  logic       locked_n;
  logic       blank;

  always_comb begin
    hb_rise  = HB_i & ~hb_l;
    vb_rise  = VB_i & ~vb_l;
    hvalid_n = hvalid | hb_rise;
    vvalid_n = vvalid | vb_rise;
    blank    = HB_i | VB_i;

    if (hb_rise)
      hcnt_n = '0;
    else if (&hcnt)
      hcnt_n = hcnt;
    else
      hcnt_n = hcnt + 10'd1;

    hs_n = hvalid_n & HB_i
         & ({1'b0, hcnt_n} >= HS_LO)
         & ({1'b0, hcnt_n} <  HS_HI);

    vcnt_n = vcnt;
    if (vb_rise)
      vcnt_n = '0;
    else if (hb_rise && VB_i && !(&vcnt))
      vcnt_n = vcnt + 6'd1;

    // VS only moves on line boundaries, but drops as soon as VB ends
    vs_n = VS;
    if (!VB_i)
      vs_n = 1'b0;
    else if (hb_rise || vb_rise)
      vs_n = vvalid_n
           & ({1'b0, vcnt_n} >= VS_LO)
           & ({1'b0, vcnt_n} <  VS_HI);

    meas    = (&hcnt) ? hcnt : hcnt + 10'd1;
    meas_en = hb_rise & hvalid;

    line_len_n  = line_len;
    match_cnt_n = match_cnt;
    if (meas_en) begin
      // a saturated line is never trusted as a match
      if (meas == line_len && !(&meas)) begin
        if (match_cnt != 2'd3)
          match_cnt_n = match_cnt + 2'd1;
      end else begin
        line_len_n  = meas;
        match_cnt_n = '0;
      end
    end
    locked_n = (match_cnt_n == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hb_l      <= 1'b0;
      vb_l      <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
      hvalid    <= 1'b0;
      vvalid    <= 1'b0;
      match_cnt <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      HB        <= 1'b0;
      VB        <= 1'b0;
      HS        <= 1'b0;
      VS        <= 1'b0;
      line_len  <= '0;
      locked    <= 1'b0;
    end else if (pxl2_cen) begin
      hb_l      <= HB_i;
      vb_l      <= VB_i;
      hcnt      <= hcnt_n;
      vcnt      <= vcnt_n;
      hvalid    <= hvalid_n;
      vvalid    <= vvalid_n;
      match_cnt <= match_cnt_n;
`ifdef JTPOPEYE_SYNC_BLANK_EN
      red       <= blank ? 3'd0 : red_i;
      green     <= blank ? 3'd0 : green_i;
      blue      <= blank ? 3'd0 : blue_i;
`else
      red       <= red_i;
      green     <= green_i;
      blue      <= blue_i;
`endif
      HB        <= HB_i;
      VB        <= VB_i;
      HS        <= hs_n;
      VS        <= vs_n;
      line_len  <= line_len_n;
      locked    <= locked_n;
    end
  end

  logic unused_blank;
  assign unused_blank = blank;

endmodule
